// File: rtl/sequential_divider.sv
// Iterative restoring divider: one quotient bit per clock with a go/done handshake.
// Optional divide-by-zero detection is enabled by defining DIV_ZERO_CHECK_EN.
module sequential_divider #(
    parameter int unsigned width  = 32,
    parameter int unsigned dWidth = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              go,
    input  logic [width-1:0]  dividend,
    input  logic [dWidth-1:0] divisor,
    output logic [width-1:0]  quotient,
    output logic [dWidth-1:0] remainder,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int unsigned CNT_W = (width > 1) ? $clog2(width) : 1;
    localparam int unsigned T_W   = dWidth + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [width-1:0]    q_q, q_d;
    logic [dWidth-1:0]   d_q, d_d;
    logic [dWidth-1:0]   r_q, r_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [width-1:0]    quotient_q, quotient_d;
    logic [dWidth-1:0]   remainder_q, remainder_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                err_q, err_d;

    // Single restoring step on the working registers
    logic [T_W-1:0]      t_c;
    logic                ge_c;
    logic [dWidth-1:0]   sub_c;
    logic [dWidth-1:0]   r_step_c;
    logic [width-1:0]    q_step_c;

    always_comb begin
        t_c      = {r_q, q_q[width-1]};
        ge_c     = (t_c >= {1'b0, d_q});
        sub_c    = t_c[dWidth-1:0] - d_q;
        r_step_c = ge_c ? sub_c : t_c[dWidth-1:0];
        q_step_c = {q_q[width-2:0], ge_c};
    end

    // Next-state and output logic
    always_comb begin
        state_d     = state_q;
        q_d         = q_q;
        d_d         = d_q;
        r_d         = r_q;
        cnt_d       = cnt_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        err_d       = err_q;

        case (state_q)
            S_IDLE: begin
                if (go) begin
                    q_d   = dividend;
                    d_d   = divisor;
                    r_d   = '0;
                    cnt_d = CNT_W'(width - 1);
`ifdef DIV_ZERO_CHECK_EN
                    if (divisor == '0) begin
                        state_d     = S_DONE;
                        done_d      = 1'b1;
                        err_d       = 1'b1;
                        busy_d      = 1'b0;
                        quotient_d  = '1;
                        remainder_d = dividend[dWidth-1:0];
                    end else begin
                        err_d   = 1'b0;
                        state_d = S_RUN;
                        busy_d  = 1'b1;
                    end
`else
                    state_d = S_RUN;
                    busy_d  = 1'b1;
`endif
                end
            end
            S_RUN: begin
                q_d = q_step_c;
                r_d = r_step_c;
                if (cnt_q == '0) begin
                    state_d     = S_DONE;
                    busy_d      = 1'b0;
                    done_d      = 1'b1;
                    quotient_d  = q_step_c;
                    remainder_d = r_step_c;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            q_q         <= '0;
            d_q         <= '0;
            r_q         <= '0;
            cnt_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            q_q         <= q_d;
            d_q         <= d_d;
            r_q         <= r_d;
            cnt_q       <= cnt_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign quotient  = quotient_q;
    assign remainder = remainder_q;
    assign busy      = busy_q;
    assign done      = done_q;
`ifdef DIV_ZERO_CHECK_EN
    assign err       = err_q;
`else
    assign err       = 1'b0;
`endif

endmodule

// File: tb/tb_sequential_divider.sv
// Directed-vector bench for sequential_divider with hand-computed results.
// Honours DIV_ZERO_CHECK_EN to select the expected divide-by-zero behaviour.
module tb_sequential_divider;

    logic        clk = 1'b0;
    logic        rst;
    logic        go;
    logic [31:0] dividend;
    logic [3:0]  divisor;
    logic [31:0] quotient;
    logic [3:0]  remainder;
    logic        busy;
    logic        done;
    logic        err;

    int n_cmp = 0;
    int n_bad = 0;

    sequential_divider #(.width(32), .dWidth(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .go        (go),
        .dividend  (dividend),
        .divisor   (divisor),
        .quotient  (quotient),
        .remainder (remainder),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle just after it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic [31:0] a, input logic [3:0] b);
        go       = 1'b1;
        dividend = a;
        divisor  = b;
        step();
        go = 1'b0;
    endtask

    // Counts edges until done, and how many of those sampled busy high
    task automatic wait_done(output int cycles, output int busy_cnt);
        cycles   = 0;
        busy_cnt = 0;
        while (done !== 1'b1 && cycles < 100) begin
            if (busy === 1'b1) busy_cnt++;
            step();
            cycles++;
        end
        if (cycles >= 100) check("done_timeout", 64'(cycles), 64'd0);
    endtask

    int cyc, bcnt, pulses;

    initial begin
        rst = 1'b1; go = 1'b0; dividend = '0; divisor = '0;
        step(); step();
        check("rst_quot", 64'(quotient), 64'd0);
        check("rst_rem",  64'(remainder), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_err",  64'(err), 64'd0);
        rst = 1'b0;
        step();

        // 100 / 7
        start(32'd100, 4'd7);
        check("a_busy_first", 64'(busy), 64'd1);
        wait_done(cyc, bcnt);
        check("a_latency", 64'(cyc), 64'd32);
        check("a_busy_cycles", 64'(bcnt), 64'd32);
        check("a_busy_at_done", 64'(busy), 64'd0);
        check("a_quot", 64'(quotient), 64'd14);
        check("a_rem",  64'(remainder), 64'd2);
        check("a_err",  64'(err), 64'd0);
        step();
        check("a_done_pulse", 64'(done), 64'd0);

        // Maximum operands
        start(32'hFFFF_FFFF, 4'd15);
        wait_done(cyc, bcnt);
        check("b_latency", 64'(cyc), 64'd32);
        check("b_quot", 64'(quotient), 64'h1111_1111);
        check("b_rem",  64'(remainder), 64'd0);
        step();

        // Small dividend, then idle hold with wiggling inputs
        start(32'd5, 4'd9);
        dividend = 32'hDEAD_BEEF;
        divisor  = 4'd1;
        wait_done(cyc, bcnt);
        check("c_quot", 64'(quotient), 64'd0);
        check("c_rem",  64'(remainder), 64'd5);
        for (int i = 0; i < 11; i++) step();
        check("c_hold_quot", 64'(quotient), 64'd0);
        check("c_hold_rem",  64'(remainder), 64'd5);
        check("c_hold_done", 64'(done), 64'd0);

        // go during RUN is ignored; outputs frozen mid-run
        start(32'd100, 4'd7);
        for (int i = 0; i < 9; i++) step();
        go = 1'b1; dividend = 32'd50; divisor = 4'd3;
        step();
        go = 1'b0;
        check("d_mid_quot", 64'(quotient), 64'd0);
        check("d_mid_rem",  64'(remainder), 64'd5);
        wait_done(cyc, bcnt);
        check("d_latency", 64'(cyc + 10), 64'd32);
        check("d_quot", 64'(quotient), 64'd14);
        check("d_rem",  64'(remainder), 64'd2);
        step();
        start(32'd50, 4'd3);
        check("e_busy_first", 64'(busy), 64'd1);
        wait_done(cyc, bcnt);
        check("e_latency", 64'(cyc), 64'd32);
        check("e_quot", 64'(quotient), 64'd16);
        check("e_rem",  64'(remainder), 64'd2);
        step();

        // Reset mid-operation
        start(32'd100, 4'd7);
        for (int i = 0; i < 15; i++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("f_busy", 64'(busy), 64'd0);
        check("f_quot", 64'(quotient), 64'd0);
        check("f_rem",  64'(remainder), 64'd0);
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            if (done === 1'b1) pulses++;
            step();
        end
        check("f_no_done", 64'(pulses), 64'd0);
        start(32'd100, 4'd7);
        wait_done(cyc, bcnt);
        check("f_quot_after", 64'(quotient), 64'd14);
        check("f_rem_after",  64'(remainder), 64'd2);
        step();

        // rst and go together: go dropped
        rst = 1'b1; go = 1'b1; dividend = 32'd100; divisor = 4'd7;
        step();
        rst = 1'b0; go = 1'b0;
        step();
        check("g_busy", 64'(busy), 64'd0);
        check("g_quot", 64'(quotient), 64'd0);

        // Divide by zero
        start(32'h1234_5678, 4'd0);
`ifdef DIV_ZERO_CHECK_EN
        check("z_done", 64'(done), 64'd1);
        check("z_busy", 64'(busy), 64'd0);
        check("z_err",  64'(err), 64'd1);
        check("z_quot", 64'(quotient), 64'hFFFF_FFFF);
        check("z_rem",  64'(remainder), 64'd8);
        step();
        check("z_err_hold", 64'(err), 64'd1);
        start(32'd100, 4'd7);
        check("z_err_clear", 64'(err), 64'd0);
        wait_done(cyc, bcnt);
        check("z_quot_after", 64'(quotient), 64'd14);
`else
        wait_done(cyc, bcnt);
        check("z_latency", 64'(cyc), 64'd32);
        check("z_err",  64'(err), 64'd0);
        check("z_quot", 64'(quotient), 64'hFFFF_FFFF);
        check("z_rem",  64'(remainder), 64'd8);
`endif
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
